// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
// Contents: FSM state encoding for the result pipe, default datapath
// dimensions, and the functional-unit source index assignments.
package alu_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_NSRC  = 8;

    localparam int SRC_ADD   = 0;
    localparam int SRC_SUB   = 1;
    localparam int SRC_AND   = 2;
    localparam int SRC_OR    = 3;
    localparam int SRC_XOR   = 4;
    localparam int SRC_CMP   = 5;
    localparam int SRC_SHIFT = 6;
    localparam int SRC_RSVD  = 7;

endpackage

// File: rtl/fifo2_sync.sv
// Two-entry synchronous FIFO with registered head.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data
//   pop        : read request (ignored while empty)
//   head       : oldest entry; holds its last value once the FIFO drains
//   count      : number of stored entries (0..2)
module fifo2_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    // Shift-style storage: head is always slot 0, so an empty FIFO keeps
    // presenting the most recently popped entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= din;
                    else                 r_tail <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end else begin
                        r_head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule

// File: rtl/alu_result_pipe.sv
// ALU result select with multi-cycle source wait and 2-entry output buffer.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data             : flattened source results, source k at [k*WIDTH +: WIDTH]
//   src_ok              : per-source done flags
//   in_sel/in_valid     : request source index / valid
//   in_ready            : request accepted when in_valid && in_ready
//   out_data/out_sel    : head result and its source index
//   out_err             : head is a timeout or illegal-select error (data 0)
//   out_valid/out_ready : output handshake
module alu_result_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int NSRC     = ALU_NSRC,
    parameter int SELW     = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [NSRC-1:0]       src_ok,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int WCW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int FW  = WIDTH + SELW + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_cnt_nxt;
    logic [SELW-1:0]  r_pend_sel;
    logic [SELW-1:0]  w_pend_sel_nxt;

    logic             w_push;
    logic [FW-1:0]    w_push_word;
    logic [FW-1:0]    w_head;
    logic [1:0]       w_count;
    logic             w_accept;
    logic             w_pop;

    logic             w_req_hit;
    logic             w_req_ok;
    logic [WIDTH-1:0] w_req_data;
    logic             w_pend_ok;
    logic [WIDTH-1:0] w_pend_data;

    // Select extraction; a request index with no matching source is illegal.
    always_comb begin
        w_req_hit   = 1'b0;
        w_req_ok    = 1'b0;
        w_req_data  = '0;
        w_pend_ok   = 1'b0;
        w_pend_data = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                w_req_hit  = 1'b1;
                w_req_ok   = src_ok[k];
                w_req_data = in_data[k*WIDTH +: WIDTH];
            end
            if (r_pend_sel == SELW'(k)) begin
                w_pend_ok   = src_ok[k];
                w_pend_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) && (w_count != 2'd2);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (w_count != 2'd0);
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_pend_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_pend_sel <= w_pend_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pend_sel_nxt = r_pend_sel;
        w_push         = 1'b0;
        w_push_word    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_req_hit) begin
                        w_push      = 1'b1;
                        w_push_word = {1'b1, in_sel, WIDTH'(0)};
                    end else if (w_req_ok) begin
                        w_push      = 1'b1;
                        w_push_word = {1'b0, in_sel, w_req_data};
                    end else begin
                        w_pend_sel_nxt = in_sel;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Space is guaranteed: entry required count<2 and nothing
                // else pushes while waiting.
                if (w_pend_ok) begin
                    w_push         = 1'b1;
                    w_push_word    = {1'b0, r_pend_sel, w_pend_data};
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else if (r_wait_cnt == WCW'(WAIT_MAX)) begin
                    w_push         = 1'b1;
                    w_push_word    = {1'b1, r_pend_sel, WIDTH'(0)};
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    fifo2_sync #(
        .WIDTH(FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_word),
        .head  (w_head),
        .count (w_count)
    );

    assign out_err  = w_head[FW-1];
    assign out_sel  = w_head[WIDTH +: SELW];
    assign out_data = w_head[WIDTH-1:0];

endmodule

// File: tb/tb_alu_result_pipe.sv
module tb_alu_result_pipe;

    localparam int W  = 32;
    localparam int N0 = 8;
    localparam int N1 = 5;
    localparam int S  = 3;
    localparam int WM = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N0*W-1:0] d0_in_data;
    logic [N0-1:0]   d0_src_ok;
    logic [S-1:0]    d0_in_sel;
    logic            d0_in_valid, d0_in_ready;
    logic [W-1:0]    d0_out_data;
    logic [S-1:0]    d0_out_sel;
    logic            d0_out_err, d0_out_valid, d0_out_ready;

    logic [N1*W-1:0] d1_in_data;
    logic [N1-1:0]   d1_src_ok;
    logic [S-1:0]    d1_in_sel;
    logic            d1_in_valid, d1_in_ready;
    logic [W-1:0]    d1_out_data;
    logic [S-1:0]    d1_out_sel;
    logic            d1_out_err, d1_out_valid, d1_out_ready;

    alu_result_pipe #(.WIDTH(W), .NSRC(N0), .SELW(S), .WAIT_MAX(WM)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .src_ok(d0_src_ok),
        .in_sel(d0_in_sel), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .out_data(d0_out_data), .out_sel(d0_out_sel), .out_err(d0_out_err),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready)
    );

    alu_result_pipe #(.WIDTH(W), .NSRC(N1), .SELW(S), .WAIT_MAX(WM)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .src_ok(d1_src_ok),
        .in_sel(d1_in_sel), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .out_data(d1_out_data), .out_sel(d1_out_sel), .out_err(d1_out_err),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [4:0]  ok;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t tbl[8];

    typedef struct {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        err;
    } item_t;
    item_t q[$];
    item_t it;
    logic        m_pend;
    logic [2:0]  m_psel;
    int          m_elapsed;
    logic        have_push, do_pop;
    int          lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d0_in_data = '0; d0_src_ok = '0; d0_in_sel = '0; d0_in_valid = 0; d0_out_ready = 0;
        d1_in_data = '0; d1_src_ok = '0; d1_in_sel = '0; d1_in_valid = 0; d1_out_ready = 0;
        for (int k = 0; k < N1; k++) d1_in_data[k*W +: W] = 32'hA000_0000 + k;

        tbl[0] = '{3'd0, 5'h1F, 32'hA000_0000, 1'b0};
        tbl[1] = '{3'd4, 5'h10, 32'hA000_0004, 1'b0};
        tbl[2] = '{3'd5, 5'h1F, 32'h0,         1'b1};
        tbl[3] = '{3'd7, 5'h1F, 32'h0,         1'b1};
        tbl[4] = '{3'd2, 5'h04, 32'hA000_0002, 1'b0};
        tbl[5] = '{3'd6, 5'h00, 32'h0,         1'b1};
        tbl[6] = '{3'd1, 5'h02, 32'hA000_0001, 1'b0};
        tbl[7] = '{3'd3, 5'h1F, 32'hA000_0003, 1'b0};

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", d0_out_valid, 0);
        chk("rst_out_data",  d0_out_data, 0);
        chk("rst_out_sel",   d0_out_sel, 0);
        chk("rst_out_err",   d0_out_err, 0);
        rst_n = 1;
        step();
        chk("rst_in_ready", d0_in_ready, 1);

        // Ready source, 1-cycle latency
        d0_out_ready = 1;
        d0_src_ok = 8'hFF;
        d0_in_data[2*W +: W] = 32'hDEADBEEF;
        d0_in_sel = 3'd2; d0_in_valid = 1;
        step();
        d0_in_valid = 0;
        chk("t1_valid", d0_out_valid, 1);
        chk("t1_data",  d0_out_data, 32'hDEADBEEF);
        chk("t1_sel",   d0_out_sel, 2);
        chk("t1_err",   d0_out_err, 0);

        // Waiting source, done flag 3 cycles later
        d0_src_ok = '0;
        d0_in_sel = 3'd6; d0_in_valid = 1;
        step();
        d0_in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_in_ready_wait", d0_in_ready, 0);
            chk("t2_no_valid_wait", d0_out_valid, 0);
            step();
        end
        d0_src_ok[6] = 1'b1;
        d0_in_data[6*W +: W] = 32'h0000_00F0;
        step();
        d0_src_ok = '0;
        chk("t2_valid", d0_out_valid, 1);
        chk("t2_data",  d0_out_data, 32'hF0);
        chk("t2_sel",   d0_out_sel, 6);
        chk("t2_err",   d0_out_err, 0);
        chk("t2_in_ready_after", d0_in_ready, 1);
        step();

        // Timeout
        d0_in_sel = 3'd6; d0_in_valid = 1;
        step();
        d0_in_valid = 0;
        lat = 1;
        while (!d0_out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("t3_latency", lat, WM + 2);
        chk("t3_valid", d0_out_valid, 1);
        chk("t3_err",   d0_out_err, 1);
        chk("t3_data",  d0_out_data, 0);
        chk("t3_sel",   d0_out_sel, 6);
        chk("t3_in_ready", d0_in_ready, 1);
        step();

        // Backpressure and ordered drain
        d0_out_ready = 0;
        d0_src_ok = 8'hFF;
        for (int k = 0; k < N0; k++) d0_in_data[k*W +: W] = 32'h1000_0000 + k;
        d0_in_sel = 3'd0; d0_in_valid = 1;
        step();
        chk("t4_in_ready_c1", d0_in_ready, 1);
        d0_in_sel = 3'd1;
        step();
        chk("t4_in_ready_c2", d0_in_ready, 0);
        d0_in_sel = 3'd3;
        step();
        chk("t4_in_ready_c3", d0_in_ready, 0);
        chk("t4_head0_data", d0_out_data, 32'h1000_0000);
        chk("t4_head0_sel",  d0_out_sel, 0);
        d0_out_ready = 1;
        step();
        chk("t4_head1_data", d0_out_data, 32'h1000_0001);
        chk("t4_head1_sel",  d0_out_sel, 1);
        chk("t4_in_ready_drain", d0_in_ready, 1);
        step();
        d0_in_valid = 0;
        chk("t4_head2_valid", d0_out_valid, 1);
        chk("t4_head2_data",  d0_out_data, 32'h1000_0003);
        chk("t4_head2_sel",   d0_out_sel, 3);
        step();
        chk("t4_empty", d0_out_valid, 0);

        // Table vectors on the 5-source instance (illegal selects 5..7)
        d1_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            d1_in_sel = tbl[i].sel;
            d1_src_ok = tbl[i].ok;
            d1_in_valid = 1;
            step();
            chk("tbl_valid", d1_out_valid, 1);
            chk("tbl_data",  d1_out_data, tbl[i].exp_data);
            chk("tbl_err",   d1_out_err, tbl[i].exp_err);
            chk("tbl_sel",   d1_out_sel, tbl[i].sel);
        end
        d1_in_valid = 0;
        step();

        // Reset in the 2nd cycle of a wait with one entry buffered
        d0_out_ready = 0;
        d0_src_ok = 8'hFF;
        d0_in_sel = 3'd0; d0_in_valid = 1;
        step();
        d0_src_ok = '0;
        d0_in_sel = 3'd6;
        step();
        d0_in_valid = 0;
        step();
        chk("t6_buffered", d0_out_valid, 1);
        chk("t6_waiting_in_ready", d0_in_ready, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t6_valid_after_rst", d0_out_valid, 0);
        chk("t6_in_ready_after_rst", d0_in_ready, 1);
        d0_out_ready = 1;
        d0_src_ok = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6_no_stale", d0_out_valid, 0);
        end
        d0_src_ok = '0;

        // Randomized run against a transaction-level model
        m_pend = 0; m_psel = '0; m_elapsed = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_in_ready", d0_in_ready, (!m_pend && q.size() < 2));
            chk("rnd_out_valid", d0_out_valid, (q.size() > 0));
            if (q.size() > 0 && d0_out_valid) begin
                chk("rnd_out_data", d0_out_data, q[0].data);
                chk("rnd_out_sel",  d0_out_sel, q[0].sel);
                chk("rnd_out_err",  d0_out_err, q[0].err);
            end
            d0_in_valid = ($urandom_range(0, 1) == 1);
            d0_in_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d0_src_ok = '1;
            else d0_src_ok = 8'($urandom & $urandom & $urandom);
            for (int k = 0; k < N0; k++) d0_in_data[k*W +: W] = $urandom;
            d0_out_ready = ($urandom_range(0, 3) != 0);

            do_pop = (q.size() > 0) && d0_out_ready;
            have_push = 0;
            if (m_pend) begin
                if (d0_src_ok[m_psel]) begin
                    it = '{d0_in_data[int'(m_psel)*W +: W], m_psel, 1'b0};
                    have_push = 1; m_pend = 0;
                end else if (m_elapsed == WM + 1) begin
                    it = '{32'h0, m_psel, 1'b1};
                    have_push = 1; m_pend = 0;
                end else begin
                    m_elapsed++;
                end
            end else if (d0_in_valid && q.size() < 2) begin
                if (d0_src_ok[d0_in_sel]) begin
                    it = '{d0_in_data[int'(d0_in_sel)*W +: W], d0_in_sel, 1'b0};
                    have_push = 1;
                end else begin
                    m_pend = 1; m_psel = d0_in_sel; m_elapsed = 1;
                end
            end
            if (do_pop) void'(q.pop_front());
            if (have_push) q.push_back(it);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_pipe.md
# alu_result_pipe

Parametrised successor to the ALU's combinational result select. Selects one of `NSRC` functional-unit results by opcode tag, waits for multi-cycle sources (shifter, future mul/div) to assert their done flag, and delivers the result through a 2-entry registered output buffer with valid/ready handshake. It sits between the ALU functional units and the writeback stage of the pipelined core, decoupling writeback stalls from ALU issue.

## Interface

Parameters:
- `WIDTH`, default 32: result data width.
- `NSRC`, default 8: number of source units.
- `SELW`, default `$clog2(NSRC)`, minimum 1: select width.
- `WAIT_MAX`, default 15: maximum cycles to wait for a source done flag before flagging an error.

Ports:
- `clk`  in  1  Single clock; all logic on the rising edge.
- `rst_n`  in  1  Reset, synchronous and active-low.
- `in_data`  in  `NSRC*WIDTH`  Flattened source results; source k occupies bits `[k*WIDTH +: WIDTH]`.
- `src_ok`  in  `NSRC`  Per-source result-valid (done) flag.
- `in_sel`  in  `SELW`  Requested source index.
- `in_valid`  in  1  Request valid.
- `in_ready`  out  1  Request accepted when `in_valid && in_ready`.
- `out_data`  out  `WIDTH`  Head-of-buffer result.
- `out_sel`  out  `SELW`  Source index of the head entry.
- `out_err`  out  1  Head entry is a timeout or illegal-select error; its data is 0.
- `out_valid`  out  1  Buffer non-empty.
- `out_ready`  in  1  Consumer accepts the head when `out_valid && out_ready`.

## Operation

- FSM states are `S_IDLE` and `S_WAIT`.
- `in_ready = (state==S_IDLE) && (count<2)`. It is driven from registers only, with no combinational path from `out_ready`.
- On accept in `S_IDLE`:
  - `in_sel >= NSRC`: push `{data 0, err 1, sel}` the same cycle; stay in `S_IDLE`.
  - `src_ok[in_sel]=1`: push `{in_data slice, err 0, sel}` the same cycle; stay in `S_IDLE`.
  - Otherwise: latch `pend_sel`, clear `wait_cnt`, go to `S_WAIT`.
- In `S_WAIT`, evaluated each cycle:
  - `src_ok[pend_sel]=1`: push `{slice, 0, pend_sel}`, go to `S_IDLE`.
  - Else if `wait_cnt==WAIT_MAX`: push `{0, 1, pend_sel}`, go to `S_IDLE`.
  - Else: `wait_cnt++`.
- Buffer space is always available for a `S_WAIT` push, because entry to `S_WAIT` required `count<2` and no other push occurs while waiting.
- Buffer is a 2-entry FIFO. Push and pop in the same cycle are legal at any count; count is unchanged and order is preserved. Pop occurs on `out_valid && out_ready`.
- When the buffer is empty, `out_data`, `out_sel` and `out_err` hold their last values. Only `out_valid` is meaningful.
- `src_ok` and `in_data` are sampled only in the push cycle. Source data need not be held afterwards.

## Timing

- Reset values: state `S_IDLE`, count 0, `wait_cnt` 0, `out_valid` 0, `out_data` 0, `out_sel` 0, `out_err` 0. `in_ready` is 1 in the first cycle after reset deasserts.
- Latency from accept to `out_valid`:
  - Ready source: 1 cycle.
  - Waiting source: 1 cycle after the cycle in which `src_ok` is seen.
  - Timeout: `WAIT_MAX+2` cycles after accept.
- Throughput: 1 result per cycle with ready sources and `out_ready` held high.
- Backpressure: with `out_ready=0`, two results are buffered, then `in_ready` drops in the next cycle.
- Reset in the middle of operation discards any pending wait and all buffered entries. No output handshake completes in the reset cycle.
- `wait_cnt` is `$clog2(WAIT_MAX+1)` bits wide and cannot wrap, because it is cleared on leaving `S_WAIT`.

## Structure

- Shared package/header `alu_pkg`:
  - State encodings `S_IDLE=1'b0`, `S_WAIT=1'b1`.
  - Default `WIDTH`/`NSRC` constants.
  - Source index constants `SRC_ADD=0`, `SRC_SUB=1`, `SRC_AND=2`, `SRC_OR=3`, `SRC_XOR=4`, `SRC_CMP=5`, `SRC_SHIFT=6`, `SRC_RSVD=7`.
- One sub-module, `fifo2_sync`. It is a parametrised 2-entry FIFO of width `WIDTH+SELW+1` with push, pop, `count` and head outputs. The top level holds the FSM, the wait counter and select extraction.

## Test plan

- Reset, then accept sel 2 with `src_ok=8'hFF` and `in_data[95:64]=32'hDEADBEEF`, `out_ready=1` -> next cycle `out_valid=1`, `out_data=32'hDEADBEEF`, `out_sel=2`, `out_err=0`.
- Accept sel 6 with `src_ok[6]=0`; assert it 3 cycles later with slice `32'h0000_00F0` -> `in_ready=0` during the wait; output appears the cycle after `src_ok[6]` rises, `err=0`.
- Accept sel 6 and never assert `src_ok[6]` -> after 17 cycles, `out_valid=1`, `out_err=1`, `out_data=0`, `out_sel=6`; `in_ready` returns to 1.
- With `out_ready=0`, issue 3 back-to-back requests (sels 0, 1, 3) -> first two accepted, `in_ready=0` from the third cycle; raise `out_ready` -> outputs drain in order 0, 1, then the third request is accepted.
- Instance with `NSRC=5`, `SELW=3`, sel 7 -> `out_err=1`, `out_data=0`, latency 1 cycle.
- Pull `rst_n` low in the 2nd cycle of a wait with one entry buffered -> next cycle `out_valid=0`, `in_ready=1`, and no stale entry ever emerges.
